// File: rtl/alu_ram_pkg.sv
// ---------------------------------------------------------------------------
// alu_ram_pkg
// Shared types and default widths for the ALU/RAM sequencer and the
// standalone ALU core.
//   alu_op_t    : 3-bit ALU opcode
//   seq_state_t : sequencer FSM state (also exported on a debug port)
// ---------------------------------------------------------------------------
package alu_ram_pkg;

   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_ADDR_WIDTH = 4;

   typedef enum logic [2:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_AND = 3'd2,
      OP_OR  = 3'd3,
      OP_XOR = 3'd4,
      OP_NOT = 3'd5,
      OP_SHL = 3'd6,
      OP_SHR = 3'd7
   } alu_op_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      EXEC  = 2'd2,
      WRITE = 2'd3
   } seq_state_t;

endpackage

// File: rtl/alu_core.sv
// ---------------------------------------------------------------------------
// alu_core
// Purely combinational ALU.
//   op     in   opcode (alu_op_t)
//   a, b   in   operands (b unused by NOT/SHL/SHR)
//   result out  DW-bit result
//   carry  out  ADD carry-out, SUB borrow, shifted-out bit for SHL/SHR,
//               0 for logic ops
//   zero   out  result == 0
// ---------------------------------------------------------------------------
module alu_core
   import alu_ram_pkg::*;
#(
   parameter int DW = DEF_DATA_WIDTH
) (
   input  alu_op_t       op,
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   output logic [DW-1:0] result,
   output logic          carry,
   output logic          zero
);

   // One extra bit on top: it holds carry/borrow for arithmetic and the
   // bit shifted out for shifts, so every op reduces to a single split.
   logic [DW:0] wide;

   always_comb begin
      wide = '0;
      case (op)
         OP_ADD:  wide = {1'b0, a} + {1'b0, b};
         // Top bit of the zero-extended difference is 1 exactly when a < b.
         OP_SUB:  wide = {1'b0, a} - {1'b0, b};
         OP_AND:  wide = {1'b0, a & b};
         OP_OR:   wide = {1'b0, a | b};
         OP_XOR:  wide = {1'b0, a ^ b};
         OP_NOT:  wide = {1'b0, ~a};
         OP_SHL:  wide = {a, 1'b0};
         OP_SHR:  wide = {a[0], 1'b0, a[DW-1:1]};
         default: wide = '0;
      endcase
   end

   assign result = wide[DW-1:0];
   assign carry  = wide[DW];
   assign zero   = (wide[DW-1:0] == '0);

endmodule

// File: rtl/alu_ram_sequencer.sv
// ---------------------------------------------------------------------------
// alu_ram_sequencer
// Accepts one ALU instruction at a time, reads both operands from a
// 2-read/1-write RAM, computes the result and writes it back.
//
// Handshake: an instruction is taken on a rising edge where cmd_valid and
// cmd_ready are both high; cmd_ready is high only in IDLE while reset_n is
// high. cmd_valid outside IDLE is ignored (no buffering).
//
// Ports
//   clock, reset_n                  clock, synchronous active-low reset
//   cmd_valid/cmd_ready             instruction handshake
//   cmd_op, cmd_src0/1, cmd_dst     instruction fields
//   addr0_read/addr1_read           RAM read addresses (driven in READ)
//   data0_read/data1_read           RAM read data (combinational)
//   addr_write/data_write/write_enable  RAM write port (active in WRITE)
//   rsp_valid                       one-cycle pulse with the write
//   rsp_data/rsp_carry/rsp_zero     committed result and flags
//   dbg_state                       current FSM state
//
// Sequence: IDLE -> READ (operands captured) -> EXEC (result captured)
//           -> WRITE (RAM written at the end of this cycle) -> IDLE
// ---------------------------------------------------------------------------
module alu_ram_sequencer
   import alu_ram_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  alu_op_t               cmd_op,
   input  logic [ADDR_WIDTH-1:0] cmd_src0,
   input  logic [ADDR_WIDTH-1:0] cmd_src1,
   input  logic [ADDR_WIDTH-1:0] cmd_dst,
   output logic [ADDR_WIDTH-1:0] addr0_read,
   output logic [ADDR_WIDTH-1:0] addr1_read,
   input  logic [DATA_WIDTH-1:0] data0_read,
   input  logic [DATA_WIDTH-1:0] data1_read,
   output logic [ADDR_WIDTH-1:0] addr_write,
   output logic [DATA_WIDTH-1:0] data_write,
   output logic                  write_enable,
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_data,
   output logic                  rsp_carry,
   output logic                  rsp_zero,
   output seq_state_t            dbg_state
);

   seq_state_t            state_q, state_d;

   alu_op_t               op_q;
   logic [ADDR_WIDTH-1:0] src0_q, src1_q, dst_q;
   logic [DATA_WIDTH-1:0] opa_q, opb_q;
   logic [DATA_WIDTH-1:0] result_q;
   logic                  carry_q, zero_q;

   logic [DATA_WIDTH-1:0] alu_result;
   logic                  alu_carry, alu_zero;
   logic                  accept;

   alu_core #(.DW(DATA_WIDTH)) u_alu (
      .op     (op_q),
      .a      (opa_q),
      .b      (opb_q),
      .result (alu_result),
      .carry  (alu_carry),
      .zero   (alu_zero)
   );

   assign accept = cmd_valid && cmd_ready;

   // Next state and the RAM/handshake strobes.
   always_comb begin
      state_d      = state_q;
      cmd_ready    = 1'b0;
      addr0_read   = '0;
      addr1_read   = '0;
      addr_write   = '0;
      write_enable = 1'b0;
      rsp_valid    = 1'b0;
      case (state_q)
         IDLE: begin
            cmd_ready = reset_n;
            if (cmd_valid && reset_n) state_d = READ;
         end
         READ: begin
            addr0_read = src0_q;
            addr1_read = src1_q;
            state_d    = EXEC;
         end
         EXEC: begin
            state_d = WRITE;
         end
         WRITE: begin
            // A reset sampled on this edge must also cancel the RAM write
            // that the same edge would otherwise perform.
            addr_write   = dst_q;
            write_enable = reset_n;
            rsp_valid    = reset_n;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         op_q     <= OP_ADD;
         src0_q   <= '0;
         src1_q   <= '0;
         dst_q    <= '0;
         opa_q    <= '0;
         opb_q    <= '0;
         result_q <= '0;
         carry_q  <= 1'b0;
         zero_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            op_q   <= cmd_op;
            src0_q <= cmd_src0;
            src1_q <= cmd_src1;
            dst_q  <= cmd_dst;
         end
         // Operands are captured here, before this instruction's own write,
         // so src == dst reads the old value.
         if (state_q == READ) begin
            opa_q <= data0_read;
            opb_q <= data1_read;
         end
         if (state_q == EXEC) begin
            result_q <= alu_result;
            carry_q  <= alu_carry;
            zero_q   <= alu_zero;
         end
      end
   end

   assign data_write = result_q;
   assign rsp_data   = result_q;
   assign rsp_carry  = carry_q;
   assign rsp_zero   = zero_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_alu_ram_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_ram_sequencer
// Drives instructions into alu_ram_sequencer connected to a behavioural
// 16x8 two-read/one-write RAM. Expected writes are pushed at each handshake
// and popped when write_enable is seen.
// ---------------------------------------------------------------------------
module tb_alu_ram_sequencer;
   import alu_ram_pkg::*;

   // ---------------- clock / reset ----------------
   logic clock = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;

   // ---------------- DUT signals ----------------
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   alu_op_t    cmd_op = OP_ADD;
   logic [3:0] cmd_src0 = '0, cmd_src1 = '0, cmd_dst = '0;
   logic [3:0] addr0_read, addr1_read, addr_write;
   logic [7:0] data0_read, data1_read, data_write;
   logic       write_enable, rsp_valid, rsp_carry, rsp_zero;
   logic [7:0] rsp_data;
   seq_state_t dbg_state;

   alu_ram_sequencer #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_op       (cmd_op),
      .cmd_src0     (cmd_src0),
      .cmd_src1     (cmd_src1),
      .cmd_dst      (cmd_dst),
      .addr0_read   (addr0_read),
      .addr1_read   (addr1_read),
      .data0_read   (data0_read),
      .data1_read   (data1_read),
      .addr_write   (addr_write),
      .data_write   (data_write),
      .write_enable (write_enable),
      .rsp_valid    (rsp_valid),
      .rsp_data     (rsp_data),
      .rsp_carry    (rsp_carry),
      .rsp_zero     (rsp_zero),
      .dbg_state    (dbg_state)
   );

   // ---------------- RAM with a bench preload port ----------------
   logic [7:0] ram_mem [16];
   logic       pre_we = 1'b0;
   logic [3:0] pre_addr = '0;
   logic [7:0] pre_data = '0;

   always @(posedge clock) begin
      if (pre_we) ram_mem[pre_addr] <= pre_data;
      else if (write_enable) ram_mem[addr_write] <= data_write;
   end
   assign data0_read = ram_mem[addr0_read];
   assign data1_read = ram_mem[addr1_read];

   // ---------------- scoreboard state ----------------
   logic [7:0]  model_mem [16];
   logic [13:0] exp_q [$];       // {dst, data, carry, zero}
   logic [13:0] mon_e;
   int total = 0;
   int bad = 0;
   int we_pulses = 0;
   int pushes = 0;
   logic [7:0] init_vals [16] = '{8'h00, 8'hF0, 8'h20, 8'h00, 8'h05, 8'h05, 8'h00, 8'h00,
                                  8'h81, 8'h3C, 8'h5A, 8'hA5, 8'h11, 8'h22, 8'h44, 8'h88};

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [8:0] alu_model(input logic [2:0] op, input logic [7:0] a,
                                            input logic [7:0] b);
      logic [8:0] r;
      case (op)
         3'd0: r = {1'b0, a} + {1'b0, b};
         3'd1: begin r[7:0] = a - b; r[8] = (a < b); end
         3'd2: r = {1'b0, a & b};
         3'd3: r = {1'b0, a | b};
         3'd4: r = {1'b0, a ^ b};
         3'd6: r = {a[7], a[6:0], 1'b0};
         3'd7: r = {a[0], 1'b0, a[7:1]};
         default: r = {1'b0, ~a};
      endcase
      return r;
   endfunction

   // ---------------- monitor ----------------
   always @(negedge clock) begin
      if (write_enable === 1'b1) begin
         we_pulses++;
         check_eq("we_in_write", 32'(dbg_state), 32'(WRITE));
         check_eq("rsp_with_we", 32'(rsp_valid), 32'd1);
         if (exp_q.size() == 0) begin
            check_eq("unexpected_write", 32'(exp_q.size()), 32'd1);
         end else begin
            mon_e = exp_q.pop_front();
            check_eq("wr_addr",   32'(addr_write), 32'(mon_e[13:10]));
            check_eq("wr_data",   32'(data_write), 32'(mon_e[9:2]));
            check_eq("rsp_data",  32'(rsp_data),   32'(mon_e[9:2]));
            check_eq("rsp_carry", 32'(rsp_carry),  32'(mon_e[1]));
            check_eq("rsp_zero",  32'(rsp_zero),   32'(mon_e[0]));
         end
      end else if (rsp_valid === 1'b1) begin
         check_eq("rsp_without_we", 32'(write_enable), 32'd1);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic preload(input int a, input logic [7:0] v);
      pre_we   = 1'b1;
      pre_addr = 4'(a);
      pre_data = v;
      tick();
      pre_we = 1'b0;
      model_mem[a] = v;
   endtask

   task automatic push_exp(input logic [2:0] op, input logic [3:0] s0, input logic [3:0] s1,
                           input logic [3:0] d);
      logic [8:0] r;
      r = alu_model(op, model_mem[s0], model_mem[s1]);
      exp_q.push_back({d, r[7:0], r[8], (r[7:0] == 8'h00)});
      model_mem[d] = r[7:0];
      pushes++;
   endtask

   // Returns just after the handshake edge (first READ cycle).
   task automatic handshake(input logic [2:0] op, input logic [3:0] s0, input logic [3:0] s1,
                            input logic [3:0] d, input bit expect_write);
      int n;
      cmd_op    = alu_op_t'(op);
      cmd_src0  = s0;
      cmd_src1  = s1;
      cmd_dst   = d;
      cmd_valid = 1'b1;
      n = 0;
      while (!cmd_ready && n < 20) begin
         tick();
         n++;
      end
      if (!cmd_ready) begin
         check_eq("ready_wait", 32'(cmd_ready), 32'd1);
         cmd_valid = 1'b0;
      end else begin
         if (expect_write) push_exp(op, s0, s1, d);
         tick();
         cmd_valid = 1'b0;
      end
   endtask

   // Counts falling edges until rsp_valid; returns at that falling edge.
   task automatic wait_rsp(output int n);
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (!rsp_valid && n < 10);
      if (!rsp_valid) check_eq("rsp_timeout", 32'(rsp_valid), 32'd1);
   endtask

   task automatic run_lit(input string tag, input logic [2:0] op, input logic [3:0] s0,
                          input logic [3:0] s1, input logic [3:0] d, input logic [7:0] ed,
                          input logic ec, input logic ez);
      int n;
      handshake(op, s0, s1, d, 1'b1);
      wait_rsp(n);
      check_eq({tag, "_lat"},   32'(n),         32'd3);
      check_eq({tag, "_data"},  32'(rsp_data),  32'(ed));
      check_eq({tag, "_carry"}, 32'(rsp_carry), 32'(ec));
      check_eq({tag, "_zero"},  32'(rsp_zero),  32'(ez));
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int n;
      int p0;

      // Reset state
      repeat (3) tick();
      @(negedge clock);
      check_eq("rst_state",  32'(dbg_state),    32'(IDLE));
      check_eq("rst_ready",  32'(cmd_ready),    32'd0);
      check_eq("rst_we",     32'(write_enable), 32'd0);
      check_eq("rst_rsp",    32'(rsp_valid),    32'd0);
      check_eq("rst_addr0",  32'(addr0_read),   32'd0);
      check_eq("rst_addrw",  32'(addr_write),   32'd0);
      check_eq("rst_dataw",  32'(data_write),   32'd0);
      check_eq("rst_rdata",  32'(rsp_data),     32'd0);
      tick();
      reset_n = 1'b1;
      @(negedge clock);
      check_eq("ready_after_rst", 32'(cmd_ready), 32'd1);
      tick();

      for (int i = 0; i < 16; i++) preload(i, init_vals[i]);

      // ADD with carry
      run_lit("add", 3'd0, 4'd1, 4'd2, 4'd3, 8'h10, 1'b1, 1'b0);
      tick();
      check_eq("mem3", 32'(ram_mem[3]), 32'h10);

      // SUB to zero, then borrow
      run_lit("sub_z", 3'd1, 4'd4, 4'd5, 4'd4, 8'h00, 1'b0, 1'b1);
      run_lit("sub_b", 3'd1, 4'd4, 4'd5, 4'd12, 8'hFB, 1'b1, 1'b0);

      // Shifts and NOT on 0x81
      run_lit("shl", 3'd6, 4'd8, 4'd8, 4'd13, 8'h02, 1'b1, 1'b0);
      run_lit("shr", 3'd7, 4'd8, 4'd8, 4'd14, 8'h40, 1'b1, 1'b0);
      run_lit("not", 3'd5, 4'd8, 4'd0, 4'd15, 8'h7E, 1'b0, 1'b0);

      // Back-to-back with cmd_valid held: XOR 1,2->6 then OR 6,6->7
      tick();
      p0 = we_pulses;
      cmd_op = OP_XOR; cmd_src0 = 4'd1; cmd_src1 = 4'd2; cmd_dst = 4'd6;
      cmd_valid = 1'b1;
      n = 0;
      while (!cmd_ready && n < 20) begin tick(); n++; end
      push_exp(3'd4, 4'd1, 4'd2, 4'd6);
      tick();
      cmd_op = OP_OR; cmd_src0 = 4'd6; cmd_src1 = 4'd6; cmd_dst = 4'd7;
      n = 0;
      while (!cmd_ready && n < 10) begin tick(); n++; end
      check_eq("b2b_gap", 32'(n + 1), 32'd4);
      push_exp(3'd3, 4'd6, 4'd6, 4'd7);
      tick();
      cmd_valid = 1'b0;
      wait_rsp(n);
      check_eq("b2b_lat", 32'(n), 32'd3);
      repeat (3) tick();
      check_eq("mem7", 32'(ram_mem[7]), 32'hD0);
      check_eq("b2b_pulses", 32'(we_pulses - p0), 32'd2);

      // cmd_valid during READ/EXEC with other fields is ignored
      p0 = we_pulses;
      handshake(3'd2, 4'd1, 4'd2, 4'd9, 1'b1);
      cmd_op = OP_ADD; cmd_src0 = 4'd4; cmd_src1 = 4'd5; cmd_dst = 4'd10;
      cmd_valid = 1'b1;
      tick();
      tick();
      cmd_valid = 1'b0;
      repeat (3) tick();
      check_eq("ign_state", 32'(dbg_state), 32'(IDLE));
      check_eq("ign_pulses", 32'(we_pulses - p0), 32'd1);
      check_eq("mem10", 32'(ram_mem[10]), 32'h5A);

      // Reset during EXEC aborts the instruction
      p0 = we_pulses;
      handshake(3'd0, 4'd1, 4'd2, 4'd11, 1'b0);
      tick();
      check_eq("abort_in_exec", 32'(dbg_state), 32'(EXEC));
      reset_n = 1'b0;
      @(negedge clock);
      check_eq("abort_ready", 32'(cmd_ready), 32'd0);
      check_eq("abort_we",    32'(write_enable), 32'd0);
      tick();
      @(negedge clock);
      check_eq("abort_state", 32'(dbg_state), 32'(IDLE));
      check_eq("abort_ready2", 32'(cmd_ready), 32'd0);
      check_eq("abort_rdata", 32'(rsp_data), 32'd0);
      tick();
      reset_n = 1'b1;
      @(negedge clock);
      check_eq("abort_ready_rel", 32'(cmd_ready), 32'd1);
      repeat (4) tick();
      check_eq("abort_pulses", 32'(we_pulses - p0), 32'd0);
      check_eq("mem11", 32'(ram_mem[11]), 32'hA5);

      // Random instructions
      for (int i = 0; i < 12; i++) begin
         handshake(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
                   4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b1);
         wait_rsp(n);
         check_eq("rnd_lat", 32'(n), 32'd3);
      end

      repeat (3) tick();
      for (int i = 0; i < 16; i++) check_eq($sformatf("mem_final_%0d", i),
                                            32'(ram_mem[i]), 32'(model_mem[i]));
      check_eq("exp_q_empty", 32'(exp_q.size()), 32'd0);
      check_eq("pulse_total", 32'(we_pulses), 32'(pushes));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_ram_sequencer.md
# alu_ram_sequencer

Command-driven initiator for the team's 16x8 two-read/one-write register RAM. It accepts one ALU instruction at a time over a valid/ready handshake and reads both source operands through the RAM's two read ports. It then computes the result and writes it back through the RAM's write port. It sits between the instruction source (bench or future decoder) and the RAM, and owns every RAM address and write-enable signal.

## Interface
- DATA_WIDTH, 8, operand/result width; must equal RAM word width
- ADDR_WIDTH, 4, RAM address width (16 entries)
- clock  in  1  rising-edge clock shared with the RAM
- reset_n  in  1  synchronous, active-low reset
- cmd_valid  in  1  instruction present
- cmd_ready  out  1  sequencer can accept an instruction
- cmd_op  in  3  opcode (alu_op_t)
- cmd_src0 / cmd_src1 / cmd_dst  in  ADDR_WIDTH each  operand and destination addresses
- addr0_read / addr1_read  out  ADDR_WIDTH  to RAM read ports
- data0_read / data1_read  in  DATA_WIDTH  from RAM; combinational w.r.t. address
- addr_write  out  ADDR_WIDTH; data_write  out  DATA_WIDTH; write_enable  out  1  to RAM write port
- rsp_valid  out  1  one-cycle pulse: result committed
- rsp_data  out  DATA_WIDTH  result written
- rsp_carry  out  1; rsp_zero  out  1  flags of that result

## Operation
- FSM states: IDLE, READ, EXEC, WRITE.
  - IDLE -> READ on cmd_valid && cmd_ready; op/src0/src1/dst latched.
  - READ -> EXEC unconditionally; addr0_read=src0, addr1_read=src1; data0_read/data1_read registered at end of cycle.
  - EXEC -> WRITE; ALU result and flags registered.
  - WRITE -> IDLE; write_enable=1, addr_write=dst, data_write=result, rsp_valid=1 in this cycle only.
- cmd_ready = (state==IDLE) && reset_n. No skid buffer. cmd_valid in other states is ignored, not queued.
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT (src0 only), 6 SHL by 1, 7 SHR by 1 (logical).
- Arithmetic at DATA_WIDTH+1 bits. ADD carry = bit DATA_WIDTH. SUB carry = borrow (src0 < src1 unsigned), result mod 2^DATA_WIDTH. SHL carry = src0 MSB. SHR carry = src0 LSB. Logic ops carry=0.
- rsp_zero = (result == 0).
- src0==src1, src==dst are legal: operands are captured before the write.

## Timing
- Handshake at edge E0 → READ cycle E0..E1, EXEC E1..E2, WRITE E2..E3; RAM updated at E3; cmd_ready high again in cycle after E3.
- Throughput: one instruction per 4 cycles with back-to-back cmd_valid.
- A following instruction reading the prior dst sees the new value (its READ is ≥1 cycle after E3).
- Reset (reset_n low at an edge): state=IDLE; all addr/data/rsp outputs 0; write_enable=0; rsp_valid=0.
- Reset mid-operation aborts the instruction: no write, no rsp_valid. A reset sampled in WRITE suppresses nothing already committed at that edge. The write that edge performs occurs only if reset_n was high.
- write_enable is never high outside WRITE. No X on any output after the first reset edge.

## Structure
- Package alu_ram_pkg: alu_op_t enum (3 bits, values above), DATA_WIDTH/ADDR_WIDTH defaults, seq_state_t enum.
- Sub-module alu_core: purely combinational, inputs op/a/b, outputs result/carry/zero. Reusable by the standalone ALU.
- Top-level: FSM, command latch, operand/result registers.
- Bench instantiates the team's RAM and connects it directly.

## Test plan
- Preload mem[1]=0xF0, mem[2]=0x20; ADD src0=1 src1=2 dst=3 -> WRITE 3 cycles after handshake, mem[3]=0x10, rsp_carry=1, rsp_zero=0.
- SUB with mem[4]=0x05, mem[5]=0x05, dst=4 -> mem[4]=0x00, rsp_zero=1, rsp_carry=0. Then SUB 0x00-0x05 -> 0xFB, carry=1.
- Back-to-back: XOR 1,2->6, then OR 6,6->7 with cmd_valid held -> second cmd_ready 4 cycles later, mem[7]=0xD0, exactly two write_enable pulses.
- SHL/SHR/NOT on 0x81 -> 0x02 c=1; 0x40 c=1; 0x7E c=0.
- reset_n low during EXEC -> no write_enable, no rsp_valid, cmd_ready low during reset, high the cycle after release, RAM unchanged.
- cmd_valid asserted during READ/EXEC with different fields -> ignored; only the latched instruction executes.
